// File: rtl/simd_lane_serializer_if.sv
// rtl/simd_lane_serializer_if.sv - vector-in / lane-out stream bundle for simd_lane_serializer
interface simd_lane_serializer_if #(
  parameter int N     = 4,
  parameter int W     = 10,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clear;
  logic          in_valid;
  logic [W-1:0]  in_data [N];
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [LW-1:0] out_lane;
  logic          out_last;
  logic          out_ready;
  logic          overflow;
  logic [CW-1:0] occupancy;

  // Producer/consumer side: drives vectors in, takes lanes out.
  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, overflow, occupancy
  );

  // Serializer side.
  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, overflow, occupancy
  );
endinterface

// File: rtl/simd_lane_serializer.sv
// rtl/simd_lane_serializer.sv - buffers N-lane result vectors and streams them out one lane per cycle
module simd_lane_serializer #(
  parameter int N     = 4,
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  simd_lane_serializer_if.slave  bus
);
  localparam int LW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  // Vector storage; contents are never reset, only the bookkeeping is.
  logic [W-1:0]  vbuf_q [DEPTH][N];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          overflow_q, overflow_d;

  logic out_valid;
  logic out_last;
  logic pop;
  logic pop_last;
  logic in_ready;
  logic accept;

  // Handshake decode: a full buffer may still accept when its head vector leaves this cycle.
  always_comb begin
    out_valid = (count_q != '0);
    out_last  = (lane_q == LAST_LANE);
    pop       = out_valid && bus.out_ready;
    pop_last  = pop && out_last;
    in_ready  = (count_q < DEPTH_C) || pop_last;
    accept    = bus.in_valid && in_ready && !bus.clear;
  end

  // Next-state for pointers, count, lane counter and sticky overflow; clear wins over everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lane_d     = lane_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      lane_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        if (out_last) begin
          lane_d   = '0;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
          lane_d   = lane_q + 1'b1;
        end
      end
      case ({accept, pop_last})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.in_valid && !in_ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
    end
  end

  // Capture an accepted vector into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (accept) begin
      vbuf_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = vbuf_q[rd_ptr_q][lane_q];
  assign bus.out_lane  = lane_q;
  assign bus.out_last  = out_last;
  assign bus.overflow  = overflow_q;
  assign bus.occupancy = count_q;
endmodule

// File: doc/simd_lane_serializer.md
Name: simd_lane_serializer

Overview:
- Sits directly downstream of the registered N-lane SIMD adder stage.
- Captures each finished N-lane result vector into a small vector buffer.
- Emits the lanes one per cycle, lane 0 first, over a valid/ready stream to narrow consumers (UART/LED/debug sinks).
- The adder stage has no backpressure, so this block absorbs bursts and flags any vector it had to drop.

Parameters:
- N, 4, number of lanes per vector; ≥2; matches the adder's lane count.
- W, 10, lane width in bits.
- DEPTH, 2, vector buffer depth in whole vectors; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of buffer, lane counter and overflow flag.
- in_valid  input  1  result vector present this cycle; supplied by the adder's valid-tracking pipe.
- in_data  input  [W-1:0] x [N-1:0] (unpacked array)  result lanes, same layout as the adder output.
- in_ready  output  1  vector will be accepted at this edge.
- out_valid  output  1  out_data holds a valid lane.
- out_data  output  W  current lane value.
- out_lane  output  $clog2(N)  index of the current lane.
- out_last  output  1  current lane is lane N-1.
- out_ready  input  1  consumer takes the lane at this edge.
- overflow  output  1  sticky: a vector was dropped.
- occupancy  output  $clog2(DEPTH)+1  number of buffered vectors, including the one being emitted.

Behaviour:
- Reset (async, rst=1): occupancy=0, write/read pointers=0, lane counter=0, overflow=0.
  - Therefore out_valid=0, out_lane=0, out_last=0, in_ready=1.
  - out_data is don't-care while out_valid=0; the bench must not check it then.
  - Buffer contents are not reset.
- Storage: circular buffer of DEPTH vectors with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Accept:
  - A vector is written when in_valid && in_ready, into buf[wr_ptr]; wr_ptr increments.
  - in_ready = (count<DEPTH) || pop_last, where pop_last = out_valid && out_ready && out_last.
  - The combinational out_ready→in_ready path is intentional: a full buffer releasing its head accepts a new vector in the same cycle.
- Emit:
  - out_valid = (count != 0).
  - out_data = buf[rd_ptr][lane]; out_lane = lane; out_last = (lane == N-1).
  - All outputs are driven directly from registers plus a mux; no combinational path from in_* to out_*.
- Lane handshake:
  - On out_valid && out_ready, lane increments.
  - On the last lane: lane←0, rd_ptr increments, count decrements.
  - While out_ready=0, out_data, out_lane and out_last hold stable.
- Latency:
  - A vector accepted at edge k into an empty buffer gives out_valid=1 with lane 0 in the cycle after edge k.
  - With out_ready held at 1, lanes leave on consecutive cycles; sustained throughput is one vector per N cycles.
- Simultaneous accept and pop_last: count is unchanged, both pointers advance.
- Overflow:
  - in_valid && !in_ready sets overflow (sticky) and drops the incoming vector.
  - count, pointers and the vector being emitted are unaffected.
  - overflow is cleared only by rst or clear.
- clear:
  - Has priority over accept and pop in the same cycle.
  - Next state: count=0, pointers=0, lane=0, overflow=0.
  - An in_valid in the clear cycle is discarded and does not set overflow.
- Reset mid-emission: the partial vector is discarded; no lane is emitted after rst deasserts until a new vector is accepted.
- No arithmetic on lane data: values pass bit-exact.

Test Plan (N=4, W=10, DEPTH=2):
1. Reset, then one vector {lane0..3 = 1,2,3,1023} with out_ready=1 → out_valid on the next 4 cycles with data 1,2,3,1023, out_lane 0..3, out_last only on 1023; then out_valid=0, occupancy=0.
2. Backpressure: vector {10,20,30,40}, out_ready toggled 1,0,0,1,1,0,1 → each lane appears once in order, and data/lane hold steady while out_ready=0.
3. Burst with out_ready=0: vectors A, B, C on consecutive cycles → A and B are stored, occupancy=2, in_ready=0, overflow=1; after draining, only the 8 lanes of A and B are emitted.
4. Full-buffer concurrent release: buffer full, out_ready=1 on A's lane 3 while in_valid presents C → in_ready=1, C is accepted, overflow stays 0, and the output stream is A, B, C.
5. clear asserted while emitting lane 1 of a buffered vector, with in_valid=1 in the same cycle → next cycle out_valid=0, occupancy=0, overflow=0, and the incoming vector is not stored.
6. Async rst pulsed between clock edges during lane 2 → outputs take reset values immediately, before the next edge; after release, a new vector emits starting at lane 0.
